// File: rtl/popcnt_pkg.sv
// Shared types and width helpers for the round-robin popcount scheduler.
package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bits needed to hold a count of 0..w ones.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Requester id width; at least one bit so a lone requester still has a port.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/popcount_rr_sched_popcount_unit.sv
// Combinational count of 1 bits in a DATA_W-bit word.
module popcount_unit #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_count
);

  // Ripple adder over the bits; zero-extend each bit into the count width.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_count = o_count + CNT_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/popcount_rr_sched.sv
// Round-robin scheduler sharing one popcount datapath between NREQ requesters.
// Optional feature: define POPCNT_ACCUM_EN for per-requester saturating totals.
module popcount_rr_sched
  import popcnt_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int ACC_W  = 16,
  localparam int ID_W  = id_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       rsp_count,
  output logic [ACC_W-1:0]       rsp_total,
  input  logic                   acc_clr
);

  state_e                        r_state, w_next;
  logic [ID_W-1:0]               r_ptr, r_id, w_gid, w_idx;
  logic [NREQ-1:0]               w_grant;
  logic                          w_any;
  logic [NREQ-1:0][DATA_W-1:0]   w_words;
  logic [DATA_W-1:0]             r_data;
  logic [CNT_W-1:0]              r_count, w_cnt;

  assign w_words = req_data;

  popcount_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pop (
    .i_data (r_data),
    .o_count(w_cnt)
  );

  // First valid requester at or after r_ptr, wrapping around.
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any          = 1'b1;
        w_gid          = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  // Next-state logic and the handshake strobes.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_any) w_next = CALC;
      end
      CALC: w_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Capture the granted word/id and advance the round-robin pointer past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_data <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_data <= w_words[w_gid];
      r_id   <= w_gid;
      r_ptr  <= (w_gid == ID_W'(NREQ - 1)) ? '0 : w_gid + ID_W'(1);
    end
  end

  // Register the count so the response fields are stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_count <= '0;
    else if (r_state == CALC)  r_count <= w_cnt;
  end

  assign rsp_id    = r_id;
  assign rsp_count = r_count;

`ifdef POPCNT_ACCUM_EN
  logic [NREQ-1:0][ACC_W-1:0] r_acc;
  logic [ACC_W-1:0]           r_total, w_sat;
  logic [ACC_W:0]             w_sum;

  assign w_sum = {1'b0, r_acc[r_id]} + (ACC_W+1)'(w_cnt);
  assign w_sat = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

  // Accumulate on the CALC->RESP edge; a clear wins over the add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_total <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
      if (r_state == CALC) r_total <= '0;
    end else if (r_state == CALC) begin
      r_acc[r_id] <= w_sat;
      r_total     <= w_sat;
    end
  end

  assign rsp_total = r_total;
`else
  logic w_unused;
  assign w_unused  = acc_clr;
  assign rsp_total = '0;
`endif

endmodule

// File: tb/tb_popcount_rr_sched.sv
// Scoreboard bench for popcount_rr_sched: spec-level model pushes expectations,
// an independent monitor pops them on every response handshake.
module tb_popcount_rr_sched;
  localparam int NREQ = 4, DATA_W = 8, CNT_W = 4, ACC_W = 16, ID_W = 2;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid, rsp_ready, acc_clr;
  logic [ID_W-1:0]        rsp_id;
  logic [CNT_W-1:0]       rsp_count;
  logic [ACC_W-1:0]       rsp_total;

  popcount_rr_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_count(rsp_count), .rsp_total(rsp_total), .acc_clr(acc_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int cnt; longint tot; } exp_t;
  exp_t   exp_q[$];
  int     gq[$];
  int     n_cmp = 0, n_err = 0;
  int     m_ptr = 0, m_phase = 0, m_id = 0, grant_cnt = 0;
  logic [DATA_W-1:0] m_data;
  longint m_acc [NREQ];
  logic [NREQ-1:0] grant_seen = '0;
  logic   first_resp;
  logic [63:0] h_id, h_cnt, h_tot, last_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration, latency and accumulator rules, sampled mid-cycle.
  always @(negedge clk) begin
    int g, cnt, idx;
    longint tot;
    if (!rst_n) begin
      m_ptr = 0; m_phase = 0; exp_q.delete();
      for (int i = 0; i < NREQ; i++) m_acc[i] = 0;
    end else begin
      case (m_phase)
        0: begin
          g = -1;
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
          end
          if (g < 0) check("idle_no_grant", 64'(req_ready), 64'd0);
          else begin
            check("grant", 64'(req_ready), 64'(1 << g));
            m_id = g; m_data = req_data[g*DATA_W +: DATA_W];
            m_ptr = (g + 1) % NREQ; m_phase = 1;
            gq.push_back(g); grant_cnt++;
          end
          grant_seen = grant_seen | req_ready;
        end
        1: begin
          check("calc_quiet", 64'({rsp_valid, req_ready}), 64'd0);
          cnt = $countones(m_data);
          tot = 0;
`ifdef POPCNT_ACCUM_EN
          if (!acc_clr) begin
            m_acc[m_id] = (m_acc[m_id] + cnt > ACC_MAX) ? ACC_MAX : m_acc[m_id] + cnt;
            tot = m_acc[m_id];
          end
`endif
          exp_q.push_back('{m_id, cnt, tot});
          m_phase = 2; first_resp = 1'b1;
        end
        default: begin
          check("resp_valid", 64'(rsp_valid), 64'd1);
          check("resp_no_ready", 64'(req_ready), 64'd0);
          if (!first_resp) begin
            check("hold_id", 64'(rsp_id), h_id);
            check("hold_cnt", 64'(rsp_count), h_cnt);
            check("hold_tot", 64'(rsp_total), h_tot);
          end
          h_id = 64'(rsp_id); h_cnt = 64'(rsp_count); h_tot = 64'(rsp_total);
          first_resp = 1'b0;
          if (rsp_ready) m_phase = 0;
        end
      endcase
`ifdef POPCNT_ACCUM_EN
      if (acc_clr) for (int i = 0; i < NREQ; i++) m_acc[i] = 0;
`endif
    end
  end

  // Monitor: pop and compare on each response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_count", 64'(rsp_count), 64'(e.cnt));
        check("rsp_total", 64'(rsp_total), 64'(e.tot));
        last_total = 64'(rsp_total);
      end
    end
  end

  task automatic send(input int i, input logic [DATA_W-1:0] d);
    int t = 0;
    req_valid[i] = 1'b1; req_data[i*DATA_W +: DATA_W] = d;
    while (!grant_seen[i] && t < 100) begin @(posedge clk); #2; t++; end
    if (t >= 100) check("send_timeout", 64'd1, 64'd0);
    grant_seen[i] = 1'b0; req_valid[i] = 1'b0;
  endtask

  task automatic idle_wait();
    int t = 0;
    while ((m_phase != 0 || exp_q.size() != 0) && t < 200) begin @(posedge clk); #2; t++; end
    if (t >= 200) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_grants(input int n);
    int t = 0;
    while (grant_cnt < n && t < 200) begin @(posedge clk); #2; t++; end
    if (t >= 200) check("grant_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] pend;
    int t, base;
    rst_n = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1; acc_clr = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_count", 64'(rsp_count), 64'd0);
    check("rst_rsp_total", 64'(rsp_total), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Round-robin: all valid, grants 0,1,2,3,0.
    gq.delete(); base = grant_cnt;
    req_data = {8'h01, 8'h0F, 8'hFF, 8'h00};
    req_valid = '1;
    wait_grants(base + 5);
    req_valid = '0; grant_seen = '0;
    idle_wait();
    if (gq.size() >= 5) begin
      check("rr_g0", 64'(gq[0]), 64'd0); check("rr_g1", 64'(gq[1]), 64'd1);
      check("rr_g2", 64'(gq[2]), 64'd2); check("rr_g3", 64'(gq[3]), 64'd3);
      check("rr_g4", 64'(gq[4]), 64'd0);
    end else check("rr_grant_count", 64'(gq.size()), 64'd5);

    // Single request with latency check.
    send(1, 8'hB5);
    @(posedge clk); #2;
    check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    check("lat_rsp_id", 64'(rsp_id), 64'd1);
    check("lat_rsp_count", 64'(rsp_count), 64'd5);
    idle_wait();

    // Wrap-around: pointer moved to 3, then req0 and req3 compete.
    send(2, 8'h01); idle_wait();
    gq.delete(); base = grant_cnt;
    req_data[0 +: 8] = 8'h81; req_data[24 +: 8] = 8'h7E;
    req_valid = 4'b1001;
    t = 0;
    while (grant_cnt < base + 2 && t < 200) begin
      @(posedge clk); #2; t++;
      req_valid = req_valid & ~grant_seen; grant_seen = '0;
    end
    req_valid = '0; grant_seen = '0;
    idle_wait();
    if (gq.size() >= 2) begin
      check("wrap_first", 64'(gq[0]), 64'd3); check("wrap_second", 64'(gq[1]), 64'd0);
    end else check("wrap_grant_count", 64'(gq.size()), 64'd2);

    // Backpressure: 10 stalled cycles, then IDLE and grant the next cycle after release.
    rsp_ready = 1'b0;
    send(2, 8'hA5);
    req_valid[3] = 1'b1; req_data[24 +: 8] = 8'h11;
    repeat (10) begin @(posedge clk); #2; end
    rsp_ready = 1'b1;
    t = 0;
    while (!grant_seen[3] && t < 20) begin @(posedge clk); #2; t++; end
    check("bp_regrant_delay", 64'(t), 64'd2);
    req_valid = '0; grant_seen = '0;
    idle_wait();

`ifdef POPCNT_ACCUM_EN
    acc_clr = 1'b1; @(posedge clk); #2 acc_clr = 1'b0;
    send(2, 8'hFF); idle_wait(); check("acc_8", last_total, 64'd8);
    send(2, 8'hFF); idle_wait(); check("acc_16", last_total, 64'd16);
    send(2, 8'hFF); idle_wait(); check("acc_24", last_total, 64'd24);
    send(2, 8'hFF); acc_clr = 1'b1; @(posedge clk); #2 acc_clr = 1'b0;
    idle_wait(); check("acc_clr_total", last_total, 64'd0);
`endif

    // Reset while a response is stalled.
    rsp_ready = 1'b0;
    send(1, 8'h3C);
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #2; t++; end
    check("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_count", 64'(rsp_count), 64'd0);
    check("midrst_rsp_total", 64'(rsp_total), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1; rsp_ready = 1'b1;
    gq.delete(); base = grant_cnt;
    req_data = {8'h0F, 8'hF0, 8'hAA, 8'h55};
    req_valid = '1;
    wait_grants(base + 1);
    req_valid = '0; grant_seen = '0;
    idle_wait();
    if (gq.size() >= 1) check("post_rst_first_grant", 64'(gq[0]), 64'd0);
    else check("post_rst_grant_count", 64'(gq.size()), 64'd1);

    // Randomized traffic.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) begin
        if (grant_seen[i]) begin grant_seen[i] = 1'b0; pend[i] = 1'b0; req_valid[i] = 1'b0; end
        if (pend[i] && $urandom_range(19) == 0) begin pend[i] = 1'b0; req_valid[i] = 1'b0; end
        else if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1; req_valid[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      acc_clr   = ($urandom_range(15) == 0);
    end
    req_valid = '0; rsp_ready = 1'b1; acc_clr = 1'b0;
    @(posedge clk); #2 grant_seen = '0;
    idle_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
